// File: rtl/branch_resolver_pkg.sv
// Shared types and constants for the fetch-prediction queue and branch resolver.
package branch_resolver_pkg;

    localparam int unsigned CNT_W = 16;
    localparam logic [31:0] PC_INCR = 32'd4;

    typedef struct packed {
        logic [31:0] pc;
        logic        taken;
        logic [31:0] target;
    } pred_entry_t;

endpackage

// File: rtl/branch_resolver_pred_fifo.sv
// In-flight prediction queue: storage, pointers, occupancy count and full/empty flags.
module pred_fifo
    import branch_resolver_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int PW = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_push,
    input  logic          i_pop,
    input  logic          i_clear,
    input  pred_entry_t   i_wdata,
    output pred_entry_t   o_rdata,
    output logic [PW:0]   o_count,
    output logic          o_full,
    output logic          o_empty
);

    pred_entry_t   r_mem [DEPTH];
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [PW:0]   r_count;

    // Storage is deliberately left out of reset; entries are only read while valid.
    always_ff @(posedge clk) begin
        if (i_push) begin
            r_mem[r_wr_ptr] <= i_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_clear) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (i_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_rdata = r_mem[r_rd_ptr];
    assign o_count = r_count;
    assign o_full  = (r_count == (PW+1)'(DEPTH));
    assign o_empty = (r_count == '0);

endmodule

// File: rtl/branch_resolver.sv
// Compares decoded branch outcomes against queued fetch predictions and issues
// a registered flush/redirect on mispredict, with saturating statistics.
module branch_resolver
    import branch_resolver_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             fetchValid,
    input  logic [31:0]      fetchPC,
    input  logic             predTaken,
    input  logic [31:0]      predPC,
    input  logic             decodeValid,
    input  logic             isBranch,
    input  logic             branchTaken,
    input  logic [31:0]      branchTargetD,
    input  logic             branchstall,
    output logic             fetchStall,
    output logic             flush,
    output logic [31:0]      redirectPC,
    output logic [CNT_W-1:0] branchCount,
    output logic [CNT_W-1:0] mispredictCount,
    output logic             underflowErr
);

    localparam int PW = $clog2(DEPTH);

    pred_entry_t      w_head;
    pred_entry_t      w_wdata;
    logic [PW:0]      w_count;
    logic             w_full;
    logic             w_empty;
    logic             w_dec_req;
    logic             w_deq;
    logic             w_enq;
    logic             w_actual_taken;
    logic             w_mispred;
    logic [31:0]      w_correct_pc;

    logic             r_flush;
    logic [31:0]      r_redirect_pc;
    logic [CNT_W-1:0] r_branch_cnt;
    logic [CNT_W-1:0] r_mispred_cnt;
    logic             r_underflow;

    assign w_dec_req      = decodeValid & ~branchstall;
    assign w_deq          = w_dec_req & ~w_empty;
    assign fetchStall     = w_full & ~w_deq;
    assign w_enq          = fetchValid & ~fetchStall;
    assign w_actual_taken = isBranch & branchTaken;

    assign w_mispred = w_deq & ((w_head.taken != w_actual_taken) |
                                (w_actual_taken & (w_head.target != branchTargetD)));

    assign w_correct_pc = w_actual_taken ? branchTargetD : (w_head.pc + PC_INCR);

    assign w_wdata = '{pc: fetchPC, taken: predTaken, target: predPC};

    // A fetch arriving alongside a mispredict is wrong-path and never enters the queue.
    pred_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_enq & ~w_mispred),
        .i_pop   (w_deq),
        .i_clear (w_mispred),
        .i_wdata (w_wdata),
        .o_rdata (w_head),
        .o_count (w_count),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_flush       <= 1'b0;
            r_redirect_pc <= '0;
            r_branch_cnt  <= '0;
            r_mispred_cnt <= '0;
            r_underflow   <= 1'b0;
        end else begin
            r_flush <= w_mispred;
            if (w_mispred) r_redirect_pc <= w_correct_pc;
            if (w_deq && isBranch && (r_branch_cnt != '1))
                r_branch_cnt <= r_branch_cnt + 1'b1;
            if (w_mispred && (r_mispred_cnt != '1))
                r_mispred_cnt <= r_mispred_cnt + 1'b1;
            if (w_dec_req && w_empty) r_underflow <= 1'b1;
        end
    end

    assign flush           = r_flush;
    assign redirectPC      = r_redirect_pc;
    assign branchCount     = r_branch_cnt;
    assign mispredictCount = r_mispred_cnt;
    assign underflowErr    = r_underflow;

endmodule

// File: tb/tb_branch_resolver.sv
// Directed-vector bench for branch_resolver: per-cycle stimulus table plus an async reset sequence.
module tb_branch_resolver;
    import branch_resolver_pkg::*;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             fetchValid = 1'b0;
    logic [31:0]      fetchPC = '0;
    logic             predTaken = 1'b0;
    logic [31:0]      predPC = '0;
    logic             decodeValid = 1'b0;
    logic             isBranch = 1'b0;
    logic             branchTaken = 1'b0;
    logic [31:0]      branchTargetD = '0;
    logic             branchstall = 1'b0;
    logic             fetchStall;
    logic             flush;
    logic [31:0]      redirectPC;
    logic [CNT_W-1:0] branchCount;
    logic [CNT_W-1:0] mispredictCount;
    logic             underflowErr;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    branch_resolver #(.DEPTH(4)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .fetchValid      (fetchValid),
        .fetchPC         (fetchPC),
        .predTaken       (predTaken),
        .predPC          (predPC),
        .decodeValid     (decodeValid),
        .isBranch        (isBranch),
        .branchTaken     (branchTaken),
        .branchTargetD   (branchTargetD),
        .branchstall     (branchstall),
        .fetchStall      (fetchStall),
        .flush           (flush),
        .redirectPC      (redirectPC),
        .branchCount     (branchCount),
        .mispredictCount (mispredictCount),
        .underflowErr    (underflowErr)
    );

    typedef struct {
        logic        fv;
        logic [31:0] fpc;
        logic        pt;
        logic [31:0] ppc;
        logic        dv;
        logic        ib;
        logic        bt;
        logic [31:0] tgt;
        logic        bs;
        logic        e_stall;
        logic        e_flush;
        logic [31:0] e_redir;
        int          e_cnt;
        int          e_bc;
        int          e_mc;
        logic        e_uerr;
    } vec_t;

    vec_t vq[$];

    function automatic vec_t mk(logic fv, logic [31:0] fpc, logic pt, logic [31:0] ppc,
                                logic dv, logic ib, logic bt, logic [31:0] tgt, logic bs,
                                logic e_stall, logic e_flush, logic [31:0] e_redir,
                                int e_cnt, int e_bc, int e_mc, logic e_uerr);
        vec_t v;
        v.fv = fv; v.fpc = fpc; v.pt = pt; v.ppc = ppc;
        v.dv = dv; v.ib = ib; v.bt = bt; v.tgt = tgt; v.bs = bs;
        v.e_stall = e_stall; v.e_flush = e_flush; v.e_redir = e_redir;
        v.e_cnt = e_cnt; v.e_bc = e_bc; v.e_mc = e_mc; v.e_uerr = e_uerr;
        return v;
    endfunction

    task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s [%0d]: got 0x%08h want 0x%08h", name, idx, act, exp);
        end
    endtask

    task automatic drive_idle();
        fetchValid = 1'b0; fetchPC = '0; predTaken = 1'b0; predPC = '0;
        decodeValid = 1'b0; isBranch = 1'b0; branchTaken = 1'b0;
        branchTargetD = '0; branchstall = 1'b0;
    endtask

    initial begin
        // Columns: fv fpc pt ppc | dv ib bt tgt bs | stall flush redir cnt bc mc uerr
        vq.push_back(mk(1, 32'h100, 1, 32'h200,  0,0,0,32'h0,   0,  0,0,32'h0,   1,0,0,0));
        vq.push_back(mk(0, 32'h0,   0, 32'h0,    1,1,1,32'h200, 0,  0,0,32'h0,   0,1,0,0));
        vq.push_back(mk(1, 32'h100, 0, 32'h0,    0,0,0,32'h0,   0,  0,0,32'h0,   1,1,0,0));
        vq.push_back(mk(1, 32'h104, 0, 32'h0,    0,0,0,32'h0,   0,  0,0,32'h0,   2,1,0,0));
        vq.push_back(mk(0, 32'h0,   0, 32'h0,    1,1,1,32'h300, 0,  0,1,32'h300, 0,2,1,0));
        vq.push_back(mk(0, 32'h0,   0, 32'h0,    0,0,0,32'h0,   0,  0,0,32'h300, 0,2,1,0));
        vq.push_back(mk(1, 32'hFFFFFFFC, 1, 32'h50, 0,0,0,32'h0, 0, 0,0,32'h300, 1,2,1,0));
        vq.push_back(mk(0, 32'h0,   0, 32'h0,    1,0,0,32'h0,   0,  0,1,32'h0,   0,2,2,0));
        vq.push_back(mk(0, 32'h0,   0, 32'h0,    0,0,0,32'h0,   0,  0,0,32'h0,   0,2,2,0));
        vq.push_back(mk(1, 32'h400, 0, 32'h0,    0,0,0,32'h0,   0,  0,0,32'h0,   1,2,2,0));
        vq.push_back(mk(1, 32'h404, 0, 32'h0,    1,1,0,32'h0,   0,  0,0,32'h0,   1,3,2,0));
        vq.push_back(mk(1, 32'h408, 0, 32'h0,    1,1,1,32'h500, 0,  0,1,32'h500, 0,4,3,0));
        vq.push_back(mk(0, 32'h0,   0, 32'h0,    0,0,0,32'h0,   0,  0,0,32'h500, 0,4,3,0));
        vq.push_back(mk(1, 32'h600, 1, 32'h700,  0,0,0,32'h0,   0,  0,0,32'h500, 1,4,3,0));
        vq.push_back(mk(0, 32'h0,   0, 32'h0,    1,1,1,32'h704, 0,  0,1,32'h704, 0,5,4,0));
        vq.push_back(mk(1, 32'h10,  0, 32'h0,    0,0,0,32'h0,   0,  0,0,32'h704, 1,5,4,0));
        vq.push_back(mk(1, 32'h14,  0, 32'h0,    0,0,0,32'h0,   0,  0,0,32'h704, 2,5,4,0));
        vq.push_back(mk(1, 32'h18,  0, 32'h0,    0,0,0,32'h0,   0,  0,0,32'h704, 3,5,4,0));
        vq.push_back(mk(1, 32'h1C,  0, 32'h0,    0,0,0,32'h0,   0,  0,0,32'h704, 4,5,4,0));
        vq.push_back(mk(1, 32'h20,  0, 32'h0,    0,0,0,32'h0,   0,  1,0,32'h704, 4,5,4,0));
        vq.push_back(mk(1, 32'h20,  0, 32'h0,    1,0,0,32'h0,   0,  0,0,32'h704, 4,5,4,0));
        vq.push_back(mk(0, 32'h0,   0, 32'h0,    1,1,1,32'h999, 1,  1,0,32'h704, 4,5,4,0));
        vq.push_back(mk(0, 32'h0,   0, 32'h0,    1,0,0,32'h0,   0,  0,0,32'h704, 3,5,4,0));
        vq.push_back(mk(0, 32'h0,   0, 32'h0,    1,0,0,32'h0,   0,  0,0,32'h704, 2,5,4,0));
        vq.push_back(mk(0, 32'h0,   0, 32'h0,    1,0,0,32'h0,   0,  0,0,32'h704, 1,5,4,0));
        vq.push_back(mk(0, 32'h0,   0, 32'h0,    1,0,0,32'h0,   0,  0,0,32'h704, 0,5,4,0));
        vq.push_back(mk(0, 32'h0,   0, 32'h0,    1,0,0,32'h0,   0,  0,0,32'h704, 0,5,4,1));
        vq.push_back(mk(0, 32'h0,   0, 32'h0,    0,0,0,32'h0,   0,  0,0,32'h704, 0,5,4,1));

        drive_idle();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_flush", -1, 32'(flush), 32'h0);
        chk("reset_redir", -1, redirectPC, 32'h0);
        chk("reset_bcnt",  -1, 32'(branchCount), 32'h0);
        chk("reset_stall", -1, 32'(fetchStall), 32'h0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        foreach (vq[i]) begin
            fetchValid = vq[i].fv; fetchPC = vq[i].fpc; predTaken = vq[i].pt; predPC = vq[i].ppc;
            decodeValid = vq[i].dv; isBranch = vq[i].ib; branchTaken = vq[i].bt;
            branchTargetD = vq[i].tgt; branchstall = vq[i].bs;
            #1;
            chk("fetchStall", i, 32'(fetchStall), 32'(vq[i].e_stall));
            @(posedge clk); #1;
            chk("flush",       i, 32'(flush), 32'(vq[i].e_flush));
            chk("redirectPC",  i, redirectPC, vq[i].e_redir);
            chk("count",       i, 32'(dut.u_fifo.o_count), 32'(vq[i].e_cnt));
            chk("branchCount", i, 32'(branchCount), 32'(vq[i].e_bc));
            chk("mispredCnt",  i, 32'(mispredictCount), 32'(vq[i].e_mc));
            chk("underflow",   i, 32'(underflowErr), 32'(vq[i].e_uerr));
        end

        // Mid-operation async reset with three queued entries.
        for (int k = 0; k < 3; k++) begin
            drive_idle();
            fetchValid = 1'b1; fetchPC = 32'h800 + 32'(4*k); predTaken = 1'b1; predPC = 32'hA00;
            @(posedge clk); #1;
        end
        drive_idle();
        chk("pre_rst_count", 0, 32'(dut.u_fifo.o_count), 32'd3);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_flush", 0, 32'(flush), 32'h0);
        chk("async_rst_redir", 0, redirectPC, 32'h0);
        chk("async_rst_bcnt",  0, 32'(branchCount), 32'h0);
        chk("async_rst_mcnt",  0, 32'(mispredictCount), 32'h0);
        chk("async_rst_uerr",  0, 32'(underflowErr), 32'h0);
        chk("async_rst_count", 0, 32'(dut.u_fifo.o_count), 32'h0);
        @(posedge clk); #3;
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            chk("post_rst_flush", k, 32'(flush), 32'h0);
            chk("post_rst_count", k, 32'(dut.u_fifo.o_count), 32'h0);
        end

        // A decode after reset release must underflow, proving the old entries are gone.
        decodeValid = 1'b1; isBranch = 1'b1; branchTaken = 1'b0;
        @(posedge clk); #1;
        drive_idle();
        chk("post_rst_underflow", 0, 32'(underflowErr), 32'h1);
        chk("post_rst_noflush",   0, 32'(flush), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/branch_resolver.md
BRANCH_RESOLVER -- requirements
Module: branch_resolver

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning the number of in-flight fetch predictions held; legal values 2..16, power of two.
REQ-002 SHALL have port clk, input, 1, meaning the single rising-edge clock.
REQ-003 SHALL have port rst_n, input, 1, meaning asynchronous active-low reset.
REQ-004 SHALL have ports fetchValid, fetchPC, input, 1/32, meaning an instruction was fetched this cycle at this PC.
REQ-005 SHALL have ports predTaken, predPC, input, 1/32, meaning the predictor's direction and target for fetchPC.
REQ-006 SHALL have ports decodeValid, isBranch, branchTaken, branchTargetD, input, 1/1/1/32, meaning the oldest in-flight instruction was decoded, and its actual direction and target.
REQ-007 SHALL have port branchstall, input, 1, meaning decode is stalled and decodeValid is ignored.
REQ-008 SHALL have port fetchStall, output, 1, meaning the queue cannot accept a fetch this cycle.
REQ-009 SHALL have ports flush, redirectPC, output, 1/32, meaning squash wrong-path fetches and restart fetch at redirectPC.
REQ-010 SHALL have ports branchCount, mispredictCount, output, 16/16, meaning saturating resolved-branch and mispredict counters.
REQ-011 SHALL have port underflowErr, output, 1, meaning sticky: decode was reported with an empty queue.

Function
REQ-012 SHALL enqueue {fetchPC, predTaken, predPC} on a rising edge when fetchValid is high and fetchStall is low.
REQ-013 SHALL drive fetchStall combinationally high when count equals DEPTH and no dequeue occurs this cycle. A dequeue in the same cycle frees one slot, so a full queue accepts the fetch.
REQ-014 SHALL perform a dequeue when decodeValid is high, branchstall is low, and count is nonzero. Comparison uses the head entry only.
REQ-015 SHALL declare a mispredict when any of the following holds:
- the head predTaken differs from (isBranch and branchTaken);
- isBranch and branchTaken are both high and the head predPC differs from branchTargetD.
REQ-016 SHALL set the corrected PC on a mispredict as follows:
- branchTargetD when isBranch and branchTaken are both high;
- otherwise head PC + 4, computed modulo 2^32 (wrap at 0xFFFFFFFC gives 0x00000000).
REQ-017 SHALL register a mispredict so that flush is a one-cycle pulse in the cycle after the dequeue edge, with redirectPC valid in that cycle.
REQ-018 SHALL hold redirectPC at its last value when flush is low.
REQ-019 SHALL, on the mispredict dequeue edge, empty the queue (count set to 0, pointers equalised). Any enqueue in that same cycle is discarded as wrong-path.
REQ-020 SHALL update the counters on each dequeue edge:
- branchCount increments when isBranch is high;
- mispredictCount increments on each mispredict;
- both saturate at 0xFFFF.
REQ-021 SHALL set underflowErr when decodeValid is high, branchstall is low, and count is zero. The queue is left unchanged.
REQ-022 SHALL, when enqueue and dequeue coincide with no mispredict, leave count unchanged and advance both pointers, with pointers wrapping modulo DEPTH.
REQ-023 SHALL produce no flush while branchstall is high, regardless of the other inputs.

Reset
REQ-024 SHALL, while rst_n is low, asynchronously force the following, independent of clk:
- count and pointers to 0;
- flush to 0 and redirectPC to 0x00000000;
- branchCount, mispredictCount and underflowErr to 0.
REQ-025 SHALL apply reset mid-operation by discarding all queued entries, with no flush emitted on release.
REQ-026 SHALL not reset queue entry storage; entries are don't-care while invalid.

Structure
REQ-027 SHALL place the following in a shared package: the entry record {pc[31:0], taken, target[31:0]}, the PC increment constant 4, and the counter width 16. The predictor and fetch stages share these.
REQ-028 SHALL implement the queue as one sub-module, pred_fifo, holding the storage, pointers, count and full/empty. Compare, redirect and counter logic stay in branch_resolver.

Verification
REQ-029 SHALL cover this correct-prediction case: enqueue PC 0x100, predTaken 1, predPC 0x200; decode isBranch 1, taken 1, target 0x200. Required: no flush, branchCount 1, mispredictCount 0.
REQ-030 SHALL cover this direction-mispredict case: enqueue PC 0x100 and 0x104, predTaken 0; decode head with isBranch 1, taken 1, target 0x300. Required: flush one cycle later, redirectPC 0x300, queue empty, mispredictCount 1.
REQ-031 SHALL cover this non-branch case: enqueue PC 0xFFFFFFFC, predTaken 1; decode isBranch 0. Required: flush, redirectPC 0x00000000.
REQ-032 SHALL cover this full-queue case: fill DEPTH=4 entries. Then:
- a 5th fetch with no decode sees fetchStall 1 and is not enqueued;
- a 5th fetch with a concurrent correct decode sees fetchStall 0, and count stays 4.
REQ-033 SHALL cover this stall and underflow case:
- decodeValid with branchstall 1 causes no dequeue and no flush;
- decodeValid on an empty queue sets underflowErr 1, and it stays 1 until reset.
REQ-034 SHALL cover this reset case: assert rst_n low mid-queue with 3 entries, asynchronously between edges. Required: all outputs zero immediately, count 0 after release, no spurious flush.
